// File: rtl/alu_seq.sv
// ============================================================================
// alu_seq: handshaked ALU (add/sub/logic/compare) with optional shift-add MUL.
// Optional feature macro: ALU_SEQ_MUL_EN (opcode 8 multiply). Revision: 1.0
// ============================================================================
`default_nettype none

module alu_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero,
   output logic             overflow,
   output logic             illegal
);

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_NOT = 4'd2;
   localparam logic [3:0] OP_AND = 4'd3;
   localparam logic [3:0] OP_OR  = 4'd4;
   localparam logic [3:0] OP_XOR = 4'd5;
   localparam logic [3:0] OP_SLT = 4'd6;
   localparam logic [3:0] OP_EQ  = 4'd7;
`ifdef ALU_SEQ_MUL_EN
   localparam logic [3:0] OP_MUL = 4'd8;
   localparam int         CNT_W  = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

   state_t state, state_next;
   logic   accept, load_sc;

   assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == DONE);

   // Shared adder: SUB, SLT and EQ all run a + ~b + 1.
   logic [WIDTH-1:0] b_eff, sc_result;
   logic [WIDTH:0]   sum;
   logic             add_ovf, sc_carry, sc_ovf, sc_illegal;

   always_comb begin
      b_eff      = (op == OP_ADD) ? b : ~b;
      sum        = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (op != OP_ADD)};
      add_ovf    = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      sc_result  = '0;
      sc_carry   = 1'b0;
      sc_ovf     = 1'b0;
      sc_illegal = 1'b0;
      case (op)
         OP_ADD, OP_SUB: begin
            sc_result = sum[WIDTH-1:0];
            sc_carry  = sum[WIDTH];
            sc_ovf    = add_ovf;
         end
         OP_NOT: sc_result = ~a;
         OP_AND: sc_result = a & b;
         OP_OR:  sc_result = a | b;
         OP_XOR: sc_result = a ^ b;
         OP_SLT: begin
            sc_result = {{(WIDTH-1){1'b0}}, add_ovf ^ sum[WIDTH-1]};
            sc_carry  = sum[WIDTH];
            sc_ovf    = add_ovf;
         end
         OP_EQ: begin
            sc_result = {{(WIDTH-1){1'b0}}, (a == b)};
            sc_carry  = sum[WIDTH];
            sc_ovf    = add_ovf;
         end
         default: sc_illegal = 1'b1;
      endcase
   end

`ifdef ALU_SEQ_MUL_EN
   logic [2*WIDTH-1:0] acc, acc_next, mcand;
   logic [WIDTH-1:0]   mplier;
   logic [CNT_W-1:0]   count;
   logic               start_mul, load_mul;

   assign acc_next = acc + (mplier[0] ? mcand : '0);
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      load_sc    = 1'b0;
`ifdef ALU_SEQ_MUL_EN
      start_mul  = 1'b0;
      load_mul   = 1'b0;
      if (state == BUSY) begin
         if (count == CNT_W'(1)) begin
            load_mul   = 1'b1;
            state_next = DONE;
         end
      end else
`endif
      if (accept) begin
`ifdef ALU_SEQ_MUL_EN
         if (op == OP_MUL) begin
            start_mul  = 1'b1;
            state_next = BUSY;
         end else
`endif
         begin
            load_sc    = 1'b1;
            state_next = DONE;
         end
      end else if ((state == DONE) && out_ready) begin
         state_next = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         result   <= '0;
         carry    <= 1'b0;
         zero     <= 1'b0;
         overflow <= 1'b0;
         illegal  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         count    <= '0;
`endif
      end else if (load_sc) begin
         result   <= sc_result;
         carry    <= sc_carry;
         zero     <= (sc_result == '0);
         overflow <= sc_ovf;
         illegal  <= sc_illegal;
      end
`ifdef ALU_SEQ_MUL_EN
      else if (start_mul) begin
         acc    <= '0;
         mcand  <= {{WIDTH{1'b0}}, a};
         mplier <= b;
         count  <= CNT_INIT;
      end else if (state == BUSY) begin
         acc    <= acc_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count - CNT_W'(1);
         if (load_mul) begin
            result   <= acc_next[WIDTH-1:0];
            carry    <= |acc_next[2*WIDTH-1:WIDTH];
            zero     <= (acc_next[WIDTH-1:0] == '0);
            overflow <= 1'b0;
            illegal  <= 1'b0;
         end
      end
`endif
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
// tb_alu_seq: directed self-checking bench for alu_seq at WIDTH=8.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_seq;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst, in_valid, out_ready;
   logic         in_ready, out_valid, carry, zero, overflow, illegal;
   logic [3:0]   op;
   logic [W-1:0] a, b, result;
   wire  [12:0]  obs = {out_valid, result, carry, zero, overflow, illegal};

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .carry(carry), .zero(zero), .overflow(overflow),
      .illegal(illegal)
   );

   // Present one op for a single edge, then drop in_valid.
   task automatic do_op(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic ordy);
      in_valid  = 1'b1;
      op        = o;
      a         = x;
      b         = y;
      out_ready = ordy;
      @(posedge clk); #1;
      in_valid  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (obs !== 13'h0) begin
         errors++;
         $display("FAIL reset_outputs: got %h exp %h", obs, 13'h0);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || obs !== 13'h0) begin
         errors++;
         $display("FAIL reset_idle: in_ready=%b obs=%h exp in_ready=1 obs=0", in_ready, obs);
      end
   endtask

   task automatic test_single_cycle();
      logic [3:0]  t_op  [9] = '{4'd0, 4'd0, 4'd1, 4'd6, 4'd7, 4'd2, 4'd3, 4'd4, 4'd1};
      logic [7:0]  t_a   [9] = '{8'h7F, 8'hFF, 8'h05, 8'h80, 8'h3C, 8'h0F, 8'hF0, 8'hF0, 8'h00};
      logic [7:0]  t_b   [9] = '{8'h01, 8'h01, 8'h05, 8'h01, 8'h3C, 8'h00, 8'h3C, 8'h0F, 8'h01};
      logic [12:0] t_exp [9] = '{
         {1'b1, 8'h80, 4'b0010},   // ADD signed overflow
         {1'b1, 8'h00, 4'b1100},   // ADD wrap: carry, zero
         {1'b1, 8'h00, 4'b1100},   // SUB equal: no borrow, zero
         {1'b1, 8'h01, 4'b1010},   // SLT -128 < 1
         {1'b1, 8'h01, 4'b1000},   // EQ true
         {1'b1, 8'hF0, 4'b0000},   // NOT
         {1'b1, 8'h30, 4'b0000},   // AND
         {1'b1, 8'hFF, 4'b0000},   // OR
         {1'b1, 8'hFF, 4'b0000}    // SUB borrow
      };
      for (int i = 0; i < 9; i++) begin
         do_op(t_op[i], t_a[i], t_b[i], 1'b1);
         checks++;
         if (obs !== t_exp[i]) begin
            errors++;
            $display("FAIL single_cycle[%0d] op=%0d: got %h exp %h", i, t_op[i], obs, t_exp[i]);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic [3:0]  t_op  [3] = '{4'd0, 4'd5, 4'd1};
      logic [7:0]  t_a   [3] = '{8'h01, 8'hAA, 8'h10};
      logic [7:0]  t_b   [3] = '{8'h02, 8'h55, 8'h01};
      logic [12:0] t_exp [3] = '{{1'b1, 8'h03, 4'b0000}, {1'b1, 8'hFF, 4'b0000},
                                 {1'b1, 8'h0F, 4'b1000}};
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         op = t_op[i];
         a  = t_a[i];
         b  = t_b[i];
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready[%0d]: got %b exp 1", i, in_ready);
         end
         @(posedge clk); #1;
         checks++;
         if (obs !== t_exp[i]) begin
            errors++;
            $display("FAIL b2b_result[%0d]: got %h exp %h", i, obs, t_exp[i]);
         end
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      logic [12:0] held = {1'b1, 8'h46, 4'b0000};
      logic [12:0] nxt  = {1'b1, 8'h0F, 4'b0000};
      do_op(4'd0, 8'h12, 8'h34, 1'b0);
      in_valid = 1'b1;
      op       = 4'd5;
      a        = 8'hF0;
      b        = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (obs !== held || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold[%0d]: obs=%h in_ready=%b exp obs=%h in_ready=0",
                     i, obs, in_ready, held);
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release_ready: got %b exp 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (obs !== nxt) begin
         errors++;
         $display("FAIL bp_next_result: got %h exp %h", obs, nxt);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_drain: out_valid got %b exp 0", out_valid);
      end
   endtask

   task automatic test_illegal();
      logic [12:0] ill = {1'b1, 8'h00, 4'b0101};
      do_op(4'd12, 8'h05, 8'h03, 1'b1);
      checks++;
      if (obs !== ill) begin
         errors++;
         $display("FAIL illegal_op12: got %h exp %h", obs, ill);
      end
`ifndef ALU_SEQ_MUL_EN
      do_op(4'd8, 8'h10, 8'h10, 1'b1);
      checks++;
      if (obs !== ill) begin
         errors++;
         $display("FAIL illegal_op8: got %h exp %h", obs, ill);
      end
`endif
      @(posedge clk); #1;
   endtask

`ifdef ALU_SEQ_MUL_EN
   task automatic test_mul();
      logic [7:0]  t_a   [2] = '{8'h10, 8'h0F};
      logic [7:0]  t_b   [2] = '{8'h10, 8'h03};
      logic [12:0] t_exp [2] = '{{1'b1, 8'h00, 4'b1100}, {1'b1, 8'h2D, 4'b0000}};
      int lat;
      for (int i = 0; i < 2; i++) begin
         do_op(4'd8, t_a[i], t_b[i], 1'b1);
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mul_busy[%0d]: in_ready=%b out_valid=%b exp 0 0", i, in_ready, out_valid);
         end
         lat = 0;
         while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
         end
         checks++;
         if (lat != W) begin
            errors++;
            $display("FAIL mul_latency[%0d]: got %0d exp %0d", i, lat, W);
         end
         checks++;
         if (obs !== t_exp[i]) begin
            errors++;
            $display("FAIL mul_result[%0d]: got %h exp %h", i, obs, t_exp[i]);
         end
         @(posedge clk); #1;
      end
   endtask
`endif

   task automatic test_reset_midop();
      logic seen;
`ifdef ALU_SEQ_MUL_EN
      do_op(4'd8, 8'h0F, 8'h03, 1'b1);
      repeat (2) begin
         @(posedge clk); #1;
      end
`else
      do_op(4'd0, 8'h01, 8'h01, 1'b0);
`endif
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (obs !== 13'h0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_midop: obs=%h in_ready=%b exp obs=0 in_ready=1", obs, in_ready);
      end
      out_ready = 1'b1;
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL reset_abandon: out_valid seen=%b exp 0", seen);
      end
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      op        = 4'd0;
      a         = '0;
      b         = '0;
      test_reset();
      test_single_cycle();
      test_back_to_back();
      test_backpressure();
      test_illegal();
`ifdef ALU_SEQ_MUL_EN
      test_mul();
`endif
      test_reset_midop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
